// File: rtl/entrada_operandos_bcd.sv
// Operand-entry stage for the BCD adder: debounced button loads A, then B+cin, then clears.
// Build option DEBOUNCE_FILTER_EN enables the counter-based level filter (otherwise one register stage).
module entrada_operandos_bcd #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] sw,
  input  logic       sw_cin,
  input  logic       btn,
  output logic [3:0] a,
  output logic [3:0] b,
  output logic       cin,
  output logic       valid,
  output logic       err,
  output logic [1:0] estado
);

  // state | meaning
  // S_A   | waiting for operand A
  // S_B   | waiting for operand B (and carry-in)
  // S_OK  | operand set complete, adder result valid
  typedef enum logic [1:0] {
    S_A  = 2'b00,
    S_B  = 2'b01,
    S_OK = 2'b10
  } state_t;

  if (DEBOUNCE_CYCLES < 2) begin : g_param_check
    $error("DEBOUNCE_CYCLES must be at least 2");
  end

  state_t state;
  logic   s1, s2;
  logic   btn_stable, btn_stable_q;
  logic   press;
  logic   sw_bcd;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= btn;
      s2 <= s1;
    end
  end

`ifdef DEBOUNCE_FILTER_EN
  localparam int            CW      = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic [CW-1:0] cnt;

  // Level is accepted only after DEBOUNCE_CYCLES consecutive mismatching samples.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt        <= '0;
      btn_stable <= 1'b0;
    end else if (s2 == btn_stable) begin
      cnt <= '0;
    end else if (cnt == CNT_MAX) begin
      cnt        <= '0;
      btn_stable <= s2;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end
`else
  always_ff @(posedge clk or posedge rst) begin
    if (rst) btn_stable <= 1'b0;
    else     btn_stable <= s2;
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) btn_stable_q <= 1'b0;
    else     btn_stable_q <= btn_stable;
  end

  assign press  = btn_stable & ~btn_stable_q;
  assign sw_bcd = (sw <= 4'd9);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_A;
      a     <= 4'd0;
      b     <= 4'd0;
      cin   <= 1'b0;
      valid <= 1'b0;
      err   <= 1'b0;
    end else begin
      case (state)
        S_A: if (press) begin
          if (sw_bcd) begin
            a     <= sw;
            err   <= 1'b0;
            state <= S_B;
          end else begin
            err <= 1'b1;
          end
        end
        S_B: if (press) begin
          if (sw_bcd) begin
            b     <= sw;
            cin   <= sw_cin;
            err   <= 1'b0;
            valid <= 1'b1;
            state <= S_OK;
          end else begin
            err <= 1'b1;
          end
        end
        S_OK: if (press) begin
          a     <= 4'd0;
          b     <= 4'd0;
          cin   <= 1'b0;
          err   <= 1'b0;
          valid <= 1'b0;
          state <= S_A;
        end
        // 2'b11 is unreachable; recover to S_A.
        default: begin
          valid <= 1'b0;
          state <= S_A;
        end
      endcase
    end
  end

  assign estado = state;

endmodule

// File: tb/tb_entrada_operandos_bcd.sv
// Self-checking bench for entrada_operandos_bcd: per-cycle model comparison plus directed literal checks.
// Works with and without DEBOUNCE_FILTER_EN; bounce-rejection vectors run only with the filter.
module tb_entrada_operandos_bcd;

  localparam int DC = 16;
`ifdef DEBOUNCE_FILTER_EN
  localparam int W = DC;
`else
  localparam int W = 1;
`endif
  localparam int LAT = W + 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] sw = 4'd0;
  logic       sw_cin = 1'b0;
  logic       btn = 1'b0;
  logic [3:0] a, b;
  logic       cin, valid, err;
  logic [1:0] estado;

  int npass = 0;
  int ntotal = 0;

  entrada_operandos_bcd #(.DEBOUNCE_CYCLES(DC)) dut (
    .clk(clk), .rst(rst), .sw(sw), .sw_cin(sw_cin), .btn(btn),
    .a(a), .b(b), .cin(cin), .valid(valid), .err(err), .estado(estado)
  );

  always #5 clk = ~clk;

  // Inputs as seen by the active edge, and whether that edge was held in reset.
  logic       smp_btn = 1'b0, smp_cin = 1'b0;
  logic [3:0] smp_sw = 4'd0;
  logic       edge_rst = 1'b1;

  always @(posedge clk) begin
    smp_btn <= btn;
    smp_sw  <= sw;
    smp_cin <= sw_cin;
  end

  always @(posedge clk or posedge rst) edge_rst <= rst;

  // Behavioural model: btn history, window-filtered level, press on rising level.
  logic [63:0] h;
  logic        m_st1, m_st2;
  int          m_state, m_a, m_b, m_cin, m_err;

  task automatic model_reset();
    h = '0; m_st1 = 1'b0; m_st2 = 1'b0;
    m_state = 0; m_a = 0; m_b = 0; m_cin = 0; m_err = 0;
  endtask

  task automatic model_step();
    logic all1, all0, pr;
    h = {h[62:0], smp_btn};
    all1 = 1'b1; all0 = 1'b1;
    for (int i = 2; i < W + 2; i++) begin
      if (h[i]) all0 = 1'b0; else all1 = 1'b0;
    end
    pr = m_st1 & ~m_st2;
    if (pr) begin
      case (m_state)
        0: if (smp_sw <= 9) begin m_a = int'(smp_sw); m_err = 0; m_state = 1; end
           else m_err = 1;
        1: if (smp_sw <= 9) begin m_b = int'(smp_sw); m_cin = int'(smp_cin); m_err = 0; m_state = 2; end
           else m_err = 1;
        default: begin m_a = 0; m_b = 0; m_cin = 0; m_err = 0; m_state = 0; end
      endcase
    end
    m_st2 = m_st1;
    if (all1) m_st1 = 1'b1;
    else if (all0) m_st1 = 1'b0;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    ntotal++;
    if (act == exp) npass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
  endtask

  initial begin
    model_reset();
    forever begin
      @(negedge clk);
      if (edge_rst) model_reset();
      else model_step();
      ntotal++;
      if (int'(a) == m_a && int'(b) == m_b && int'(cin) == m_cin &&
          valid == (m_state == 2) && int'(err) == m_err && int'(estado) == m_state)
        npass++;
      else
        $display("FAIL cycle_model: got a=%0d b=%0d cin=%0d valid=%0d err=%0d estado=%0d, expected a=%0d b=%0d cin=%0d valid=%0d err=%0d estado=%0d (t=%0t)",
                 a, b, cin, valid, err, estado, m_a, m_b, m_cin, (m_state == 2), m_err, m_state, $time);
    end
  end

  // Advance n edges, return at posedge+2 where inputs are driven.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic press(input logic [3:0] v, input logic c);
    sw = v; sw_cin = c; btn = 1'b1;
    tick(LAT + 2);
    btn = 1'b0;
    tick(LAT + 2);
  endtask

  // Count edges until estado leaves 'from'; btn must have been raised before edge 1.
  task automatic measure(input logic [1:0] from, input int exp, input string nm);
    int lat = 0;
    for (int i = 1; i <= LAT + 20; i++) begin
      @(posedge clk);
      #1;
      if (estado != from) begin
        lat = i;
        break;
      end
    end
    chk(nm, lat, exp);
    #1;
  endtask

  task automatic sum_chk(input string nm, input int exp);
    chk(nm, int'(a) + int'(b) + int'(cin), exp);
  endtask

  initial begin
    tick(3);
    chk("rst_a", int'(a), 0);
    chk("rst_valid", int'(valid), 0);
    chk("rst_estado", int'(estado), 0);
    rst = 1'b0;
    tick(2);

    // 3 + 4, with first-press latency
    sw = 4'd3; btn = 1'b1;
    measure(2'b00, LAT, "lat_first_press");
    chk("a_after_3", int'(a), 3);
    chk("estado_after_3", int'(estado), 1);
    btn = 1'b0;
    tick(LAT + 2);
    press(4'd4, 1'b0);
    chk("a_34", int'(a), 3);
    chk("b_34", int'(b), 4);
    chk("cin_34", int'(cin), 0);
    chk("valid_34", int'(valid), 1);
    chk("estado_34", int'(estado), 2);
    sum_chk("sum_34", 7);

    press(4'd0, 1'b0);
    chk("clear_valid", int'(valid), 0);
    chk("clear_a", int'(a), 0);
    press(4'd6, 1'b0);
    press(4'd7, 1'b0);
    sum_chk("sum_67", 13);
    press(4'd0, 1'b0);
    chk("clear2_b", int'(b), 0);
    press(4'd7, 1'b0);
    press(4'd9, 1'b0);
    sum_chk("sum_79", 16);
    press(4'd0, 1'b0);

    // invalid code in S_A
    press(4'd12, 1'b0);
    chk("err_12", int'(err), 1);
    chk("estado_12", int'(estado), 0);
    chk("a_12", int'(a), 0);
    press(4'd5, 1'b0);
    chk("err_5", int'(err), 0);
    chk("a_5", int'(a), 5);
    chk("estado_5", int'(estado), 1);
    press(4'd15, 1'b0);
    chk("err_b15", int'(err), 1);
    chk("estado_b15", int'(estado), 1);
    press(4'd9, 1'b1);
    chk("cin_91", int'(cin), 1);
    sum_chk("sum_591", 15);
    press(4'd0, 1'b0);

    // held button: exactly one step
    sw = 4'd2; btn = 1'b1;
    tick(200);
    chk("held_a", int'(a), 2);
    chk("held_estado", int'(estado), 1);
    btn = 1'b0;
    tick(LAT + 2);
    chk("held_release_estado", int'(estado), 1);

`ifdef DEBOUNCE_FILTER_EN
    sw = 4'd3;
    btn = 1'b1; tick(10);
    btn = 1'b0; tick(3);
    btn = 1'b1; tick(10);
    btn = 1'b0; tick(20);
    chk("bounce_estado", int'(estado), 1);
    chk("bounce_b", int'(b), 0);
    btn = 1'b1;
    measure(2'b01, 19, "lat_bounce_hold");
    btn = 1'b0;
    tick(LAT + 2);
    chk("bounce_b_loaded", int'(b), 3);
`else
    press(4'd3, 1'b0);
`endif
    chk("pre_reset_estado", int'(estado), 2);
    press(4'd0, 1'b0);
    press(4'd8, 1'b0);
    chk("pre_reset_a", int'(a), 8);

    // reset mid-debounce, button held through release
    sw = 4'd1; btn = 1'b1;
    tick(LAT - 2);
    #1 rst = 1'b1;
    #1;
    chk("async_rst_a", int'(a), 0);
    chk("async_rst_estado", int'(estado), 0);
    chk("async_rst_err_valid", int'({err, valid, cin}), 0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    measure(2'b00, LAT, "lat_after_reset");
    chk("post_reset_a", int'(a), 1);
    btn = 1'b0;
    tick(LAT + 2);

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

endmodule
